fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Handshake and ROM-port bundle for fetch_stage; slave is the fetch stage, master the environment.
interface fetch_stage_if #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_BITS  = $clog2(DEPTH)
);
  logic                  start_i;
  logic [ADDR_BITS-1:0]  rom_addr_o;
  logic [WORD_WIDTH-1:0] rom_data_i;
  logic                  redirect_i;
  logic [ADDR_BITS-1:0]  redirect_pc_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [WORD_WIDTH-1:0] instr_o;
  logic [ADDR_BITS-1:0]  pc_o;
  logic                  done_o;

  modport slave (
    input  start_i, rom_data_i, redirect_i, redirect_pc_i, ready_i,
    output rom_addr_o, valid_o, instr_o, pc_o, done_o
  );

  modport master (
    output start_i, rom_data_i, redirect_i, redirect_pc_i, ready_i,
    input  rom_addr_o, valid_o, instr_o, pc_o, done_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC + IDLE/FETCH/DONE FSM feeding a 2-entry {instr, pc} FIFO
// toward decode, with flushing redirect support.
module fetch_stage #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_BITS  = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

  localparam logic [ADDR_BITS-1:0] LastPc = ADDR_BITS'(DEPTH - 1);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] pc_q, pc_d;
  logic [1:0]           count_q, count_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;

  logic [WORD_WIDTH-1:0] instr_mem_q [2];
  logic [ADDR_BITS-1:0]  pc_mem_q    [2];

  logic empty;
  logic valid;
  logic push;
  logic pop;

  always_comb begin
    empty = (count_q == 2'd0);
    valid = !empty && !bus.redirect_i;
    pop   = valid && bus.ready_i;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push  = (state_q == StFetch) && !bus.redirect_i && ((count_q != 2'd2) || pop);

    bus.rom_addr_o = pc_q;
    bus.valid_o    = valid;
    bus.instr_o    = empty ? '0 : instr_mem_q[rd_ptr_q];
    bus.pc_o       = empty ? '0 : pc_mem_q[rd_ptr_q];
    bus.done_o     = (state_q == StDone) && empty;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (bus.redirect_i) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      pc_d     = bus.redirect_pc_i;
      state_d  = (32'(bus.redirect_pc_i) >= DEPTH) ? StDone : StFetch;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start_i) state_d = StFetch;
        end
        StFetch: begin
          if (push) begin
            // The last word ends the program; PC parks there rather than wrapping.
            if (pc_q == LastPc) state_d = StDone;
            else                pc_d    = pc_q + ADDR_BITS'(1);
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase

      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage needs no reset: reads are gated by count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_mem_q[wr_ptr_q] <= bus.rom_data_i;
      pc_mem_q[wr_ptr_q]    <= pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for reset/backpressure/redirect/reset-priority,
// plus hand-written full-program, redirect-from-DONE and mid-stream reset sequences.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if #(.WORD_WIDTH(16), .DEPTH(16)) bus ();

  fetch_stage #(.WORD_WIDTH(16), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM contents: word at address a is 0xA500 + a.
  assign bus.rom_data_i = 16'hA500 + 16'(bus.rom_addr_o);

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit rst, start, ready, redir;
    int rpc;
    bit e_valid, e_head;
    int e_pc, e_addr;
    bit e_done;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(int r, int s, int rd, int rdir, int rpc,
                              int ev, int eh, int epc, int eaddr, int edone);
    vec_t v;
    v.rst = r[0]; v.start = s[0]; v.ready = rd[0]; v.redir = rdir[0]; v.rpc = rpc;
    v.e_valid = ev[0]; v.e_head = eh[0]; v.e_pc = epc; v.e_addr = eaddr; v.e_done = edone[0];
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input int r, input int s, input int rd, input int rdir, input int rpc);
    rst               = r[0];
    bus.start_i       = s[0];
    bus.ready_i       = rd[0];
    bus.redirect_i    = rdir[0];
    bus.redirect_pc_i = 4'(rpc);
  endtask

  task automatic check_outs(input string tag, input int ev, input int eh, input int epc,
                            input int eaddr, input int edone);
    int exp_instr;
    int exp_pc;
    exp_instr = (eh != 0) ? (32'hA500 + epc) : 0;
    exp_pc    = (eh != 0) ? epc : 0;
    chk({tag, " valid"}, int'(bus.valid_o), ev);
    chk({tag, " instr"}, int'(bus.instr_o), exp_instr);
    chk({tag, " pc"}, int'(bus.pc_o), exp_pc);
    chk({tag, " addr"}, int'(bus.rom_addr_o), eaddr);
    chk({tag, " done"}, int'(bus.done_o), edone);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //               rst st rdy rdr rpc | val head pc addr done
    vecs[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0,  0,  0);  // held in reset
    vecs[1]  = mk(0, 1, 0, 0, 0,  0, 0, 0,  0,  0);  // start in IDLE
    vecs[2]  = mk(0, 0, 0, 0, 0,  0, 0, 0,  0,  0);  // FETCH, FIFO empty
    vecs[3]  = mk(0, 0, 0, 0, 0,  1, 1, 0,  1,  0);
    vecs[4]  = mk(0, 0, 0, 0, 0,  1, 1, 0,  2,  0);  // full {0,1}
    vecs[5]  = mk(0, 0, 0, 0, 0,  1, 1, 0,  2,  0);  // hold under backpressure
    vecs[6]  = mk(0, 0, 1, 0, 0,  1, 1, 0,  2,  0);  // pop+push at full
    vecs[7]  = mk(0, 0, 1, 0, 0,  1, 1, 1,  3,  0);
    vecs[8]  = mk(0, 0, 0, 0, 0,  1, 1, 2,  4,  0);
    vecs[9]  = mk(0, 0, 1, 0, 0,  1, 1, 2,  4,  0);
    vecs[10] = mk(0, 0, 0, 0, 0,  1, 1, 3,  5,  0);  // full {3,4}
    vecs[11] = mk(0, 0, 1, 1, 9,  0, 1, 3,  5,  0);  // redirect masks valid
    vecs[12] = mk(0, 0, 1, 0, 0,  0, 0, 0,  9,  0);  // flushed
    vecs[13] = mk(0, 0, 1, 0, 0,  1, 1, 9,  10, 0);
    vecs[14] = mk(0, 0, 1, 0, 0,  1, 1, 10, 11, 0);
    vecs[15] = mk(1, 1, 1, 1, 4,  0, 1, 11, 12, 0);  // rst beats start+redirect
    vecs[16] = mk(0, 0, 1, 0, 0,  0, 0, 0,  0,  0);
    vecs[17] = mk(0, 0, 1, 0, 0,  0, 0, 0,  0,  0);  // still IDLE, nothing pushed

    drive(1, 0, 0, 0, 0);
    repeat (2) tick();

    for (int i = 0; i < 18; i++) begin
      drive(int'(vecs[i].rst), int'(vecs[i].start), int'(vecs[i].ready),
            int'(vecs[i].redir), vecs[i].rpc);
      #1;
      check_outs($sformatf("vec%0d", i), int'(vecs[i].e_valid), int'(vecs[i].e_head),
                 vecs[i].e_pc, vecs[i].e_addr, int'(vecs[i].e_done));
      tick();
    end

    // Full program with ready held high: pc 0..15 in cycles 2..17, done from 18.
    drive(1, 0, 1, 0, 0);
    tick();
    for (int c = 0; c < 20; c++) begin
      int ev;
      int addr;
      drive(0, (c == 0) ? 1 : 0, 1, 0, 0);
      #1;
      ev   = (c >= 2 && c <= 17) ? 1 : 0;
      addr = (c == 0) ? 0 : ((c - 1 > 15) ? 15 : c - 1);
      check_outs($sformatf("run c%0d", c), ev, ev, c - 2, addr, (c >= 18) ? 1 : 0);
      tick();
    end

    // Redirect out of DONE to pc 2; refetch 2..15 then DONE again.
    drive(0, 0, 1, 1, 2);
    #1;
    check_outs("redir_done k0", 0, 0, 0, 15, 1);
    tick();
    for (int k = 1; k < 18; k++) begin
      int ev;
      drive(0, 0, 1, 0, 0);
      #1;
      ev = (k >= 2 && k <= 15) ? 1 : 0;
      check_outs($sformatf("redir_done k%0d", k), ev, ev, k,
                 (k + 1 > 15) ? 15 : k + 1, (k >= 16) ? 1 : 0);
      tick();
    end

    // Mid-stream reset with FIFO holding {6,7}.
    drive(1, 0, 1, 0, 0);
    tick();
    for (int c = 0; c < 8; c++) begin
      int ev;
      drive(0, (c == 0) ? 1 : 0, 1, 0, 0);
      #1;
      ev = (c >= 2) ? 1 : 0;
      check_outs($sformatf("mrst c%0d", c), ev, ev, c - 2, (c == 0) ? 0 : c - 1, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    #1;
    check_outs("mrst c8", 1, 1, 6, 7, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    #1;
    check_outs("mrst c9", 1, 1, 6, 8, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    check_outs("mrst c10", 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 1, 0, 0);
    #1;
    check_outs("mrst c11", 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    #1;
    check_outs("mrst c12", 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    #1;
    check_outs("mrst c13", 1, 1, 0, 1, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    #1;
    check_outs("mrst c14", 1, 1, 1, 2, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
